serial_transmitter: RTL

//  Async serial transmitter; sits directly upstream of the serial receiver, driving its rxd line.
//  - Accepts one N-bit word from a parallel producer via the dav_/rfd handshake.
//  - Serialises it LSB first: one start bit (0), N data bits, STOP_BITS stop bits (1).
//  - Each bit held on txd for exactly K clocks. Line idles at mark (1).

---
 rtl/serial_transmitter_pkg.sv | 21 ++
 rtl/serial_bit_timer.sv | 29 ++
 rtl/serial_transmitter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_transmitter_pkg.sv
// Constants and state encoding shared by the serial transmitter and receiver.
// Both ends of the link must agree on line levels, so they live here.
package serial_transmitter_pkg;

  localparam logic MARK      = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_START,
    ST_DATA,
    ST_STOP
  } txState_t;

  // Bits needed to hold values below maxValue, never less than one bit.
  function automatic int counterWidth(input int maxValue);
    return (maxValue < 2) ? 1 : $clog2(maxValue);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Loadable down-counter with terminal-count flag; paces bit times on the serial line.
// It stops at zero, so it never wraps while the owner is not reloading it.
module serial_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/serial_transmitter.sv
// Async serial transmitter: takes a word over the dav_/rfd handshake and sends it
// LSB first framed by one start bit and STOP_BITS stop bits, K clocks per bit.
module serial_transmitter
  import serial_transmitter_pkg::*;
#(
  parameter int N         = 8,
  parameter int K         = 16,
  parameter int STOP_BITS = 1
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] data,
  input  logic         dav_,
  output logic         rfd,
  output logic         txd
);

  localparam int WAIT_W  = counterWidth(STOP_BITS * K);
  localparam int COUNT_W = counterWidth(N + 1);

  localparam logic [WAIT_W-1:0]  BIT_RELOAD  = WAIT_W'(K - 1);
  localparam logic [WAIT_W-1:0]  STOP_RELOAD = WAIT_W'(STOP_BITS * K - 1);
  localparam logic [COUNT_W-1:0] COUNT_INIT  = COUNT_W'(N);
  localparam logic [COUNT_W-1:0] COUNT_ONE   = COUNT_W'(1);

  txState_t r_state;
  txState_t w_stateNext;

  logic [N-1:0]       r_buf;
  logic [N-1:0]       w_bufNext;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_countNext;
  logic               r_txd;
  logic               w_txdNext;
  logic               r_rfd;
  logic               w_rfdNext;

  logic              w_timerLoad;
  logic [WAIT_W-1:0] w_timerValue;
  logic              w_timerDone;

  serial_bit_timer #(
    .WIDTH (WAIT_W)
  ) u_bitTimer (
    .clock   (clock),
    .reset_  (reset_),
    .i_load  (w_timerLoad),
    .i_value (w_timerValue),
    .o_done  (w_timerDone)
  );

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // txd and rfd are registered so the line only moves on a clock edge or reset.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_txd   <= MARK;
      r_rfd   <= 1'b1;
      r_buf   <= '0;
      r_count <= '0;
    end else begin
      r_txd   <= w_txdNext;
      r_rfd   <= w_rfdNext;
      r_buf   <= w_bufNext;
      r_count <= w_countNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_bufNext    = r_buf;
    w_countNext  = r_count;
    w_txdNext    = r_txd;
    w_rfdNext    = r_rfd;
    w_timerLoad  = 1'b0;
    w_timerValue = BIT_RELOAD;

    case (r_state)
      ST_IDLE: begin
        w_txdNext = MARK;
        w_rfdNext = 1'b1;
        if (!dav_) begin
          w_bufNext   = data;
          w_rfdNext   = 1'b0;
          w_stateNext = ST_ACK;
        end
      end

      ST_ACK: begin
        w_txdNext = MARK;
        w_rfdNext = 1'b0;
        if (dav_) begin
          w_txdNext   = START_BIT;
          w_countNext = COUNT_INIT;
          w_timerLoad = 1'b1;
          w_stateNext = ST_START;
        end
      end

      // COUNT reaching zero means the last data bit has just served its time.
      ST_START, ST_DATA: begin
        if (w_timerDone) begin
          w_timerLoad = 1'b1;
          if (r_count == '0) begin
            w_txdNext    = MARK;
            w_timerValue = STOP_RELOAD;
            w_stateNext  = ST_STOP;
          end else begin
            w_txdNext   = r_buf[0];
            w_bufNext   = r_buf >> 1;
            w_countNext = r_count - COUNT_ONE;
            w_stateNext = ST_DATA;
          end
        end
      end

      ST_STOP: begin
        if (w_timerDone) begin
          w_rfdNext   = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end

      default: begin
        w_txdNext   = MARK;
        w_rfdNext   = 1'b1;
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign txd = r_txd;
  assign rfd = r_rfd;

endmodule
